// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel AXI4-Lite PWM: register word indices,
// CTRL/STATUS bit positions, response code and address/strobe helpers.
package pwm_pkg;

    localparam int unsigned REG_CTRL   = 0;
    localparam int unsigned REG_PERIOD = 1;
    localparam int unsigned REG_STATUS = 2;
    localparam int unsigned REG_COUNT  = 3;
    localparam int unsigned REG_DUTY0  = 4;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_INV    = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;
    localparam int unsigned CTRL_W      = 3;
    localparam int unsigned STATUS_PEND = 0;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Byte address to word index; the two low address bits are ignored.
    function automatic int unsigned addr_to_idx(input logic [31:0] addr);
        return 32'(addr[31:2]);
    endfunction

    function automatic logic [31:0] apply_strb(input logic [31:0] old,
                                               input logic [31:0] data,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_core.sv
// PWM engine: shared counter, shadow-to-active loading at wrap or while disabled,
// per-channel compare with polarity and a combinational wrap indication.
module pwm_core import pwm_pkg::*; #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic                           inv,
    input  logic [CNT_W-1:0]               period_sh,
    input  logic [NUM_CH-1:0][CNT_W-1:0]   duty_sh,
    output logic [CNT_W-1:0]               cnt,
    output logic [NUM_CH-1:0]              pwm,
    output logic                           wrap_c
);

    logic [CNT_W-1:0]             period_act;
    logic [NUM_CH-1:0][CNT_W-1:0] duty_act;

    assign wrap_c = en && (cnt == period_act);

    // Disabled: hold at zero and keep actives tracking shadows so enable starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            period_act <= '0;
            duty_act   <= '0;
            pwm        <= '0;
        end else if (!en) begin
            cnt        <= '0;
            period_act <= period_sh;
            duty_act   <= duty_sh;
            pwm        <= {NUM_CH{inv}};
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                pwm[k] <= (cnt < duty_act[k]) ^ inv;
            end
            if (wrap_c) begin
                cnt        <= '0;
                period_act <= period_sh;
                duty_act   <= duty_sh;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/axi_pwm_multi.sv
// AXI4-Lite register file for the multi-channel PWM; instantiates pwm_core.
// Optional period-end interrupt (irq_o, STATUS.PEND, CTRL.IRQ_EN) under PWM_IRQ_EN.
module axi_pwm_multi import pwm_pkg::*; #(
    parameter int unsigned NUM_CH             = 4,
    parameter int unsigned CNT_W              = 16,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [3:0]                      S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_CH-1:0]               pwm_o
`ifdef PWM_IRQ_EN
   ,output logic                            irq_o
`endif
);

`ifdef PWM_IRQ_EN
    localparam logic [CTRL_W-1:0] CTRL_WMASK = 3'b111;
`else
    localparam logic [CTRL_W-1:0] CTRL_WMASK = 3'b011;
`endif

    logic                         aw_ready, b_valid, ar_ready, r_valid;
    logic [31:0]                  r_data;
    logic [CTRL_W-1:0]            ctrl;
    logic [CNT_W-1:0]             period_sh;
    logic [NUM_CH-1:0][CNT_W-1:0] duty_sh;
    logic [CNT_W-1:0]             cnt;
    logic                         wrap_c, wr_en_c, rd_en_c;
    int unsigned                  wr_idx_c, rd_idx_c;
    logic [31:0]                  rd_val_c, status_c;
    logic                         unused_c;

    assign wr_idx_c = addr_to_idx(32'(S_AXI_AWADDR));
    assign rd_idx_c = addr_to_idx(32'(S_AXI_ARADDR));
    assign wr_en_c  = aw_ready & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_en_c  = ar_ready & S_AXI_ARVALID;
    assign unused_c = ^{S_AXI_AWPROT, S_AXI_ARPROT, wrap_c};

    // Write channel: single-cycle AW/W ready pulse, response held until BREADY.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_ready <= 1'b0;
            b_valid  <= 1'b0;
        end else begin
            aw_ready <= !aw_ready && S_AXI_AWVALID && S_AXI_WVALID && !b_valid;
            if (wr_en_c)           b_valid <= 1'b1;
            else if (S_AXI_BREADY) b_valid <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ctrl      <= '0;
            period_sh <= '0;
            duty_sh   <= '0;
        end else if (wr_en_c) begin
            if (wr_idx_c == REG_CTRL && S_AXI_WSTRB[0]) begin
                ctrl <= S_AXI_WDATA[CTRL_W-1:0] & CTRL_WMASK;
            end
            if (wr_idx_c == REG_PERIOD) begin
                period_sh <= CNT_W'(apply_strb(32'(period_sh), S_AXI_WDATA, S_AXI_WSTRB));
            end
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (wr_idx_c == REG_DUTY0 + k) begin
                    duty_sh[k] <= CNT_W'(apply_strb(32'(duty_sh[k]), S_AXI_WDATA, S_AXI_WSTRB));
                end
            end
        end
    end

`ifdef PWM_IRQ_EN
    logic pend;

    // A wrap in the same cycle as a write-1-to-clear keeps PEND set.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pend  <= 1'b0;
            irq_o <= 1'b0;
        end else begin
            if (wrap_c) begin
                pend <= 1'b1;
            end else if (wr_en_c && wr_idx_c == REG_STATUS && S_AXI_WSTRB[0]
                         && S_AXI_WDATA[STATUS_PEND]) begin
                pend <= 1'b0;
            end
            irq_o <= pend & ctrl[CTRL_IRQ_EN];
        end
    end

    assign status_c = 32'(pend);
`else
    assign status_c = '0;
`endif

    always_comb begin
        rd_val_c = '0;
        if (rd_idx_c == REG_CTRL)        rd_val_c = 32'(ctrl);
        else if (rd_idx_c == REG_PERIOD) rd_val_c = 32'(period_sh);
        else if (rd_idx_c == REG_STATUS) rd_val_c = status_c;
        else if (rd_idx_c == REG_COUNT)  rd_val_c = 32'(cnt);
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (rd_idx_c == REG_DUTY0 + k) rd_val_c = 32'(duty_sh[k]);
        end
    end

    // Read channel: data captured at the address handshake, so it reflects pre-write state.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else begin
            ar_ready <= !ar_ready && S_AXI_ARVALID && !r_valid;
            if (rd_en_c) begin
                r_valid <= 1'b1;
                r_data  <= rd_val_c;
            end else if (S_AXI_RREADY) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = aw_ready;
    assign S_AXI_BVALID  = b_valid;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RVALID  = r_valid;
    assign S_AXI_RDATA   = r_data;
    assign S_AXI_RRESP   = RESP_OKAY;

    pwm_core #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) u_core (
        .clk       (ACLK),
        .rst_n     (ARESETN),
        .en        (ctrl[CTRL_EN]),
        .inv       (ctrl[CTRL_INV]),
        .period_sh (period_sh),
        .duty_sh   (duty_sh),
        .cnt       (cnt),
        .pwm       (pwm_o),
        .wrap_c    (wrap_c)
    );

endmodule

// File: tb/tb_axi_pwm_multi.sv
// Self-checking bench for axi_pwm_multi (NUM_CH=4, CNT_W=16); IRQ checks under PWM_IRQ_EN.
module tb_axi_pwm_multi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [3:0]  pwm;
`ifdef PWM_IRQ_EN
    logic        irq;
    localparam logic [31:0] CTRL_RB = 32'h6;
`else
    localparam logic [31:0] CTRL_RB = 32'h2;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int hi_cnt[4];

    always #5 clk = ~clk;

    axi_pwm_multi dut (
        .ACLK(clk), .ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .pwm_o(pwm)
`ifdef PWM_IRQ_EN
       ,.irq_o(irq)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        check("aw_handshake", 32'(n < 20), 1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        check("bvalid_seen", 32'(n < 20), 1);
        check("bresp", 32'(bresp), 0);
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] addr, output logic [31:0] data);
        int n;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        check("ar_handshake", 32'(n < 20), 1);
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        check("rvalid_seen", 32'(n < 20), 1);
        check("rresp", 32'(rresp), 0);
        data = rdata;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic count_high(input int cycles);
        for (int k = 0; k < 4; k++) hi_cnt[k] = 0;
        repeat (cycles) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) if (pwm[k]) hi_cnt[k]++;
        end
    endtask

    // Active cycles over whole periods: min(duty, period+1) per period, complemented when inverted.
    function automatic int exp_high(input int period, input int duty, input bit inv, input int periods);
        int per, on;
        per = period + 1;
        on  = (duty < per) ? duty : per;
        return periods * (inv ? per - on : on);
    endfunction

`ifdef PWM_IRQ_EN
    task automatic wait_irq(input string name);
        int n;
        n = 0;
        while (irq !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check(name, 32'(irq), 1);
    endtask
`endif

    typedef struct {
        logic [5:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [5:0]  raddr;
        logic [31:0] rexp;
    } vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[12];
        logic [31:0] rd;
        logic        q[$];
        int          runs[$];
        int          len, n, aw_n, w_n, ar_n, bv_n, rv_n;
        logic        prev, found, aw_done, ar_done, rd_stable;
        logic [31:0] rd_first;

        tbl[0]  = '{6'h04, 32'hDEADBEEF, 4'hF, 6'h04, 32'h0000BEEF};
        tbl[1]  = '{6'h04, 32'h00001200, 4'h2, 6'h04, 32'h000012EF};
        tbl[2]  = '{6'h05, 32'h00000034, 4'h1, 6'h07, 32'h00001234};
        tbl[3]  = '{6'h10, 32'h0000ABCD, 4'hF, 6'h10, 32'h0000ABCD};
        tbl[4]  = '{6'h1F, 32'h00010005, 4'hF, 6'h1C, 32'h00000005};
        tbl[5]  = '{6'h20, 32'h00000055, 4'hF, 6'h20, 32'h00000000};
        tbl[6]  = '{6'h3C, 32'h00000077, 4'hF, 6'h3C, 32'h00000000};
        tbl[7]  = '{6'h0C, 32'h00000099, 4'hF, 6'h0C, 32'h00000000};
        tbl[8]  = '{6'h08, 32'h00000001, 4'hF, 6'h08, 32'h00000000};
        tbl[9]  = '{6'h00, 32'h00000006, 4'hF, 6'h00, CTRL_RB};
        tbl[10] = '{6'h00, 32'h000000FF, 4'h0, 6'h00, CTRL_RB};
        tbl[11] = '{6'h00, 32'h00000000, 4'hF, 6'h00, 32'h00000000};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awready", 32'(awready), 0);
        check("rst_wready", 32'(wready), 0);
        check("rst_bvalid", 32'(bvalid), 0);
        check("rst_arready", 32'(arready), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_rdata", rdata, 0);
        check("rst_pwm", 32'(pwm), 0);
`ifdef PWM_IRQ_EN
        check("rst_irq", 32'(irq), 0);
`endif
        rst_n = 1'b1;
        for (int a = 0; a < 64; a += 4) begin
            axi_read(6'(a), rd);
            check($sformatf("rst_read_%0h", a), rd, 0);
        end

        // Register map, strobes, truncation, unmapped and read-only behaviour
        for (int i = 0; i < 12; i++) begin
            axi_write(tbl[i].waddr, tbl[i].wdata, tbl[i].wstrb);
            axi_read(tbl[i].raddr, rd);
            check($sformatf("table_%0d", i), rd, tbl[i].rexp);
        end

        // Basic duty ratios, including DUTY=0 and DUTY>PERIOD
        axi_write(6'h04, 9, 4'hF);
        axi_write(6'h10, 3, 4'hF);
        axi_write(6'h14, 0, 4'hF);
        axi_write(6'h18, 10, 4'hF);
        axi_write(6'h1C, 5, 4'hF);
        axi_write(6'h00, 1, 4'hF);
        repeat (3) @(negedge clk);
        count_high(30);
        check("basic_ch0", hi_cnt[0], 9);
        check("basic_ch1", hi_cnt[1], 0);
        check("basic_ch2", hi_cnt[2], 30);
        check("basic_ch3", hi_cnt[3], 15);

        // Mid-period duty change: current period keeps old duty, next uses the new one
        prev = pwm[0];
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!prev && pwm[0]) begin found = 1'b1; break; end
            prev = pwm[0];
        end
        check("mid_sync", 32'(found), 1);
        fork
            begin
                q.push_back(pwm[0]);
                repeat (39) begin @(negedge clk); q.push_back(pwm[0]); end
            end
            begin
                axi_write(6'h10, 7, 4'hF);
                axi_read(6'h10, rd);
                check("mid_readback", rd, 7);
            end
        join
        len = 0;
        foreach (q[i]) begin
            if (q[i]) len++;
            else if (len > 0) begin runs.push_back(len); len = 0; end
        end
        check("mid_runs", 32'(runs.size() >= 3), 1);
        if (runs.size() >= 3) begin
            check("mid_run_old", runs[0], 3);
            check("mid_run_new", runs[1], 7);
            check("mid_run_next", runs[2], 7);
        end

        // Polarity
        axi_write(6'h00, 2, 4'hF);
        repeat (3) @(negedge clk);
        check("inv_disabled", 32'(pwm), 32'hF);
        axi_write(6'h10, 3, 4'hF);
        axi_write(6'h00, 3, 4'hF);
        repeat (3) @(negedge clk);
        count_high(30);
        check("inv_ch0", hi_cnt[0], 21);
        check("inv_ch1", hi_cnt[1], 30);
        check("inv_ch2", hi_cnt[2], 0);
        check("inv_ch3", hi_cnt[3], 15);
        axi_write(6'h00, 0, 4'hF);
        @(negedge clk);
        check("disable_pwm", 32'(pwm), 0);
        axi_read(6'h0C, rd);
        check("disable_count", rd, 0);

        // Simultaneous AW/W/AR with delayed BREADY/RREADY
        @(negedge clk);
        awaddr = 6'h04; wdata = 32'h22; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 6'h04; arvalid = 1'b1;
        aw_n = 0; w_n = 0; ar_n = 0; bv_n = 0; rv_n = 0;
        aw_done = 1'b0; ar_done = 1'b0; rd_stable = 1'b1; rd_first = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (aw_done) begin awvalid = 1'b0; wvalid = 1'b0; end
            if (ar_done) arvalid = 1'b0;
            if (awready) begin aw_n++; aw_done = 1'b1; end
            if (wready) w_n++;
            if (arready) begin ar_n++; ar_done = 1'b1; end
            if (bvalid) bv_n++;
            if (rvalid) begin
                if (rv_n == 0) rd_first = rdata;
                else if (rdata !== rd_first) rd_stable = 1'b0;
                rv_n++;
            end
        end
        check("conc_awready_pulses", aw_n, 1);
        check("conc_wready_pulses", w_n, 1);
        check("conc_arready_pulses", ar_n, 1);
        check("conc_bvalid_held", bv_n, 9);
        check("conc_rvalid_held", rv_n, 9);
        check("conc_rdata_prewrite", rd_first, 9);
        check("conc_rdata_stable", 32'(rd_stable), 1);
        check("conc_bresp", 32'(bresp), 0);
        check("conc_rresp", 32'(rresp), 0);
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        check("conc_bvalid_drop", 32'(bvalid), 0);
        check("conc_rvalid_drop", 32'(rvalid), 0);
        bready = 1'b0; rready = 1'b0;
        axi_read(6'h04, rd);
        check("conc_period_new", rd, 32'h22);

        // Randomised configurations against the duty-ratio model
        for (int it = 0; it < 6; it++) begin
            int p;
            int d[4];
            bit inv;
            p   = (it == 0) ? 0 : int'($urandom_range(15, 1));
            inv = 1'($urandom_range(1, 0));
            axi_write(6'h00, 0, 4'hF);
            axi_write(6'h04, 32'(p), 4'hF);
            for (int k = 0; k < 4; k++) begin
                d[k] = int'($urandom_range(p + 2, 0));
                axi_write(6'(16 + 4 * k), 32'(d[k]), 4'hF);
            end
            axi_write(6'h00, {30'd0, inv, 1'b1}, 4'hF);
            repeat (2) @(negedge clk);
            count_high(2 * (p + 1));
            for (int k = 0; k < 4; k++) begin
                check($sformatf("rand_%0d_p%0d_d%0d_i%0d_ch%0d", it, p, d[k], inv, k),
                      hi_cnt[k], exp_high(p, d[k], inv, 2));
            end
            axi_read(6'h0C, rd);
            check($sformatf("rand_%0d_count_range", it), 32'(rd <= 32'(p)), 1);
        end

`ifdef PWM_IRQ_EN
        // Period-end interrupt, write-1-to-clear, re-assertion
        axi_write(6'h00, 0, 4'hF);
        axi_write(6'h08, 1, 4'hF);
        axi_write(6'h04, 4, 4'hF);
        axi_read(6'h08, rd);
        check("irq_status_clear0", rd, 0);
        check("irq_low0", 32'(irq), 0);
        axi_write(6'h00, 5, 4'hF);
        wait_irq("irq_first_wrap");
        axi_read(6'h08, rd);
        check("irq_status_set", rd, 1);
        axi_write(6'h00, 4, 4'hF);
        axi_write(6'h08, 1, 4'hF);
        repeat (2) @(negedge clk);
        check("irq_cleared", 32'(irq), 0);
        axi_read(6'h08, rd);
        check("irq_status_cleared", rd, 0);
        axi_write(6'h00, 5, 4'hF);
        wait_irq("irq_rewrap");
        axi_read(6'h00, rd);
        check("irq_ctrl_rb", rd, 5);
`endif

        // Asynchronous reset while a read response is pending
        @(negedge clk);
        araddr = 6'h00; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        check("rstmid_rvalid_seen", 32'(n < 20), 1);
        arvalid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_rvalid", 32'(rvalid), 0);
        check("rstmid_rdata", rdata, 0);
        check("rstmid_arready", 32'(arready), 0);
        check("rstmid_pwm", 32'(pwm), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
